// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped branch target buffer with 2-bit counters and mispredict stats
module branch_predictor #(
    parameter int INDEX_BITS = 3,
    parameter int PC_WIDTH   = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [PC_WIDTH-1:0]  if_pc,
    output logic                 predicted_taken,
    output logic [PC_WIDTH-1:0]  predicted_target,
    input  logic                 res_valid,
    input  logic [PC_WIDTH-1:0]  res_pc,
    input  logic                 res_pred_taken,
    input  logic [PC_WIDTH-1:0]  res_pred_target,
    input  logic                 actual_taken,
    input  logic [PC_WIDTH-1:0]  actual_target,
    output logic                 update_PC,
    output logic [PC_WIDTH-1:0]  correct_pc,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = PC_WIDTH - INDEX_BITS - 1;

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_W-1:0]    tag_q [ENTRIES];
    logic [1:0]          ctr_q [ENTRIES];
    logic [PC_WIDTH-1:0] tgt_q [ENTRIES];

    logic [INDEX_BITS-1:0] if_idx;
    logic [TAG_W-1:0]      if_tag;
    logic                  if_hit;
    logic [INDEX_BITS-1:0] res_idx;
    logic [TAG_W-1:0]      res_tag;
    logic                  res_hit;
    logic [PC_WIDTH-1:0]   res_pc_plus2;
    logic                  do_update;
    logic                  mispredict;
    logic [1:0]            next_ctr;

    // Bit 0 of the PC is always ignored: instructions are halfword aligned.
    assign if_idx  = if_pc[INDEX_BITS:1];
    assign if_tag  = if_pc[PC_WIDTH-1:INDEX_BITS+1];
    assign res_idx = res_pc[INDEX_BITS:1];
    assign res_tag = res_pc[PC_WIDTH-1:INDEX_BITS+1];

    assign if_hit  = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign res_hit = valid_q[res_idx] && (tag_q[res_idx] == res_tag);

    assign predicted_taken  = if_hit & ctr_q[if_idx][1];
    assign predicted_target = if_hit ? tgt_q[if_idx] : if_pc + PC_WIDTH'(2);

    assign res_pc_plus2 = res_pc + PC_WIDTH'(2);
    assign do_update    = res_valid & en;
    // A stale target only matters when the branch was actually taken.
    assign mispredict   = (res_pred_taken != actual_taken) |
                          (actual_taken & (res_pred_target != actual_target));
    assign update_PC    = rst_n & do_update & mispredict;
    assign correct_pc   = actual_taken ? actual_target : res_pc_plus2;

    always_comb begin
        next_ctr = ctr_q[res_idx];
        if (!res_hit) begin
            next_ctr = actual_taken ? 2'b10 : 2'b01;
        end else if (actual_taken) begin
            if (next_ctr != 2'b11) next_ctr = next_ctr + 2'b01;
        end else begin
            if (next_ctr != 2'b00) next_ctr = next_ctr - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q          <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                ctr_q[i] <= 2'b01;
                tgt_q[i] <= '0;
            end
        end else if (do_update) begin
            valid_q[res_idx] <= 1'b1;
            tag_q[res_idx]   <= res_tag;
            ctr_q[res_idx]   <= next_ctr;
            if (actual_taken) begin
                tgt_q[res_idx] <= actual_target;
            end else if (!res_hit) begin
                tgt_q[res_idx] <= res_pc_plus2;
            end
            if (branch_count != '1) begin
                branch_count <= branch_count + CNT_WIDTH'(1);
            end
            if (mispredict && (mispredict_count != '1)) begin
                mispredict_count <= mispredict_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 3, giving 2**INDEX_BITS direct-mapped entries.
REQ-002 SHALL have parameter PC_WIDTH, default 16, the address width.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, the statistics counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  update enable; low during pipeline stall, which blocks all state updates.
REQ-007 if_pc  input  PC_WIDTH  fetch-stage PC to predict.
REQ-008 predicted_taken  output  1  combinational taken prediction for if_pc.
REQ-009 predicted_target  output  PC_WIDTH  combinational target for if_pc.
REQ-010 res_valid  input  1  the resolving (ID-stage) instruction is a branch (B/BR).
REQ-011 res_pc  input  PC_WIDTH  PC of the resolving branch.
REQ-012 res_pred_taken  input  1  prediction carried down the pipe with the branch.
REQ-013 res_pred_target  input  PC_WIDTH  predicted target carried down the pipe with the branch.
REQ-014 actual_taken  input  1  resolved direction.
REQ-015 actual_target  input  PC_WIDTH  resolved target.
REQ-016 update_PC  output  1  mispredict; IF must redirect and flush.
REQ-017 correct_pc  output  PC_WIDTH  redirect address.
REQ-018 branch_count  output  CNT_WIDTH  resolved branches.
REQ-019 mispredict_count  output  CNT_WIDTH  mispredicted branches.

Function
REQ-020 Index SHALL be pc[INDEX_BITS:1]; tag SHALL be pc[PC_WIDTH-1:INDEX_BITS+1]; pc[0] SHALL be ignored.
REQ-021 Each entry SHALL hold a valid bit, a tag, a 2-bit counter (00 SNT, 01 WNT, 10 WT, 11 ST), and a target.
REQ-022 hit SHALL equal valid AND tag match; predicted_taken SHALL equal hit AND counter[1]; predicted_target SHALL equal the entry target on hit, else if_pc+2 (modulo 2**PC_WIDTH).
REQ-023 update_PC SHALL equal res_valid AND en AND ((res_pred_taken != actual_taken) OR (actual_taken AND res_pred_target != actual_target)).
REQ-024 A target difference on a not-taken branch SHALL NOT raise update_PC.
REQ-025 correct_pc SHALL equal actual_target when actual_taken is high, else res_pc+2; it SHALL be driven regardless of update_PC.
REQ-026 Updates SHALL occur only on a clock edge with res_valid AND en both high.
REQ-027 On a hit, the counter SHALL increment if taken and decrement if not, saturating at 11 and 00.
REQ-028 On a hit with actual_taken high, the target SHALL be written with actual_target; a not-taken branch SHALL leave the target unchanged.
REQ-029 On a miss (invalid or tag mismatch), the entry SHALL be allocated: valid=1, tag written, counter = 10 if taken else 01, target = actual_target if taken else res_pc+2.
REQ-030 On a hit, an update SHALL leave the tag unchanged.
REQ-031 Same-cycle read and update of one index: prediction SHALL use the pre-edge contents (no bypass); the new value SHALL be visible the following cycle.
REQ-032 branch_count SHALL increment once per update cycle.
REQ-033 mispredict_count SHALL increment once per cycle in which update_PC is high.
REQ-034 Both counters SHALL saturate at all-ones and never wrap.
REQ-035 With en low, no entry or counter SHALL change and update_PC SHALL be 0.

Reset
REQ-036 rst_n low SHALL immediately clear all valid bits, set all counters to 01, clear all targets and tags, and zero both statistics counters, independent of clk.
REQ-037 During reset, predicted_taken SHALL be 0, predicted_target SHALL be if_pc+2, and update_PC SHALL be 0.
REQ-038 Reset asserted mid-update SHALL discard the update; the first edge after deassertion SHALL be a normal edge.

Verification
REQ-039 Reset, then if_pc=0x0010 -> predicted_taken=0, predicted_target=0x0012, both counts 0.
REQ-040 Resolve res_pc=0x0010 taken to 0x0040 with pred 0/0x0012 -> update_PC=1, correct_pc=0x0040, mispredict_count=1; next cycle if_pc=0x0010 -> taken, 0x0040.
REQ-041 Four taken updates at 0x0010 then three not-taken updates -> counter path 10,11,11,11,10,01,00; prediction at 0x0010 is not-taken after the 2nd not-taken update.
REQ-042 After entry 0x0010 is allocated, resolve 0x0020 (same index, different tag) not-taken -> entry reallocated with counter 01; if_pc=0x0010 then misses.
REQ-043 Not-taken resolve with res_pred_taken=0 and res_pred_target=0x1234 -> update_PC=0, correct_pc=res_pc+2.
REQ-044 Hold en=0 with res_valid=1 for 3 cycles -> no count or entry change; with CNT_WIDTH=2, 5 mispredicts -> mispredict_count=3 (saturated).
